// File: rtl/avalon_s_rr_arbiter_if.sv
// Avalon-MM bundle between NH hosts, the round-robin arbiter and the single shared device.
// slave: the arbiter's view of the bundle; master: the hosts plus the device.
interface avalon_s_rr_arbiter_if #(
  parameter int NH = 2,
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [NH-1:0]                hosts_avn_read;
  logic [NH-1:0]                hosts_avn_write;
  logic [NH-1:0][AW-1:0]        hosts_avn_address;
  logic [NH-1:0][DW/8-1:0]      hosts_avn_byte_enable;
  logic [NH-1:0][DW-1:0]        hosts_avn_writedata;
  logic [NH-1:0][DW-1:0]        hosts_avn_readdata;
  logic [NH-1:0]                hosts_avn_waitrequest;

  logic                         device_avn_read;
  logic                         device_avn_write;
  logic [AW-1:0]                device_avn_address;
  logic [DW/8-1:0]              device_avn_byte_enable;
  logic [DW-1:0]                device_avn_writedata;
  logic [DW-1:0]                device_avn_readdata;
  logic                         device_avn_waitrequest;

  modport slave (
    input  hosts_avn_read, hosts_avn_write, hosts_avn_address,
    input  hosts_avn_byte_enable, hosts_avn_writedata,
    output hosts_avn_readdata, hosts_avn_waitrequest,
    output device_avn_read, device_avn_write, device_avn_address,
    output device_avn_byte_enable, device_avn_writedata,
    input  device_avn_readdata, device_avn_waitrequest
  );

  modport master (
    output hosts_avn_read, hosts_avn_write, hosts_avn_address,
    output hosts_avn_byte_enable, hosts_avn_writedata,
    input  hosts_avn_readdata, hosts_avn_waitrequest,
    input  device_avn_read, device_avn_write, device_avn_address,
    input  device_avn_byte_enable, device_avn_writedata,
    output device_avn_readdata, device_avn_waitrequest
  );
endinterface

// File: rtl/avalon_s_rr_arbiter.sv
// Round-robin share of one Avalon-MM device among NH hosts; grant 1 cycle after an idle request, >=2 cycles/transfer.
// Only the owner sees the device waitrequest; every other host is stalled with waitrequest high.
module avalon_s_rr_arbiter #(
  parameter int NH = 2,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input logic                  clk,
  input logic                  rst,
  avalon_s_rr_arbiter_if.slave bus
);
  localparam int            GW   = (NH > 1) ? $clog2(NH) : 1;
  localparam logic [GW-1:0] LAST = GW'(NH - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [NH-1:0] req;
  logic [GW-1:0] gnt_inc;
  logic [GW-1:0] pick;
  logic          found;

  assign req     = bus.hosts_avn_read | bus.hosts_avn_write;
  assign gnt_inc = (gnt_q == LAST) ? '0 : gnt_q + GW'(1);

  // First requester at or after ptr, wrapping modulo NH.
  always_comb begin : rr_pick
    int            idx;
    logic [GW-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 0; i < NH; i++) begin
      idx  = (int'(ptr_q) + i) % NH;
      cand = GW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = pick;
        end
      end
      GRANT: begin
        // Completion and abandonment both release the device and rotate priority.
        if (!req[gnt_q] || !bus.device_avn_waitrequest) begin
          state_d = IDLE;
          ptr_d   = gnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.device_avn_read        = 1'b0;
    bus.device_avn_write       = 1'b0;
    bus.device_avn_address     = bus.hosts_avn_address[gnt_q];
    bus.device_avn_byte_enable = bus.hosts_avn_byte_enable[gnt_q];
    bus.device_avn_writedata   = bus.hosts_avn_writedata[gnt_q];
    bus.hosts_avn_waitrequest  = '1;
    bus.hosts_avn_readdata     = {NH{bus.device_avn_readdata}};
    if (state_q == GRANT) begin
      bus.device_avn_read              = bus.hosts_avn_read[gnt_q];
      bus.device_avn_write             = bus.hosts_avn_write[gnt_q];
      bus.hosts_avn_waitrequest[gnt_q] = bus.device_avn_waitrequest;
    end
  end
endmodule

// File: tb/tb_avalon_s_rr_arbiter.sv
// Bench for avalon_s_rr_arbiter: directed NH=2 sequences, then an NH=4 instance under random
// host/device traffic compared each cycle against a transaction-level round-robin model.
module tb_avalon_s_rr_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  avalon_s_rr_arbiter_if #(.NH(2), .DW(DW), .AW(AW)) b2 ();
  avalon_s_rr_arbiter_if #(.NH(4), .DW(DW), .AW(AW)) b4 ();

  avalon_s_rr_arbiter #(.NH(2), .DW(DW), .AW(AW)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  avalon_s_rr_arbiter #(.NH(4), .DW(DW), .AW(AW)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  // NH=4 host state and reference model
  logic          act [4];
  logic          hrd [4];
  logic          hwr [4];
  logic [AW-1:0] haddr [4];
  logic [DW-1:0] hdat [4];
  logic [3:0]    hbe [4];
  bit            cont [4];
  int            others [4];
  logic          dw4;
  int            obs [$];
  int            w13_low;
  bit            m_busy;
  int            m_owner;
  int            m_next;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c2(input string tag, input logic rd, input logic wr,
                    input logic [1:0] wt, input logic [AW-1:0] ad);
    @(negedge clk);
    chk({tag, ".rd"},   b2.device_avn_read, rd);
    chk({tag, ".wr"},   b2.device_avn_write, wr);
    chk({tag, ".wait"}, b2.hosts_avn_waitrequest, wt);
    chk({tag, ".addr"}, b2.device_avn_address, ad);
  endtask

  task automatic newtx(input int h);
    int r;
    r        = $urandom_range(0, 19);
    hrd[h]   = (r < 10);
    hwr[h]   = (r == 0) || (r >= 10);
    haddr[h] = $urandom;
    hdat[h]  = $urandom;
    hbe[h]   = 4'($urandom_range(1, 15));
    act[h]   = 1'b1;
    others[h] = 0;
  endtask

  task automatic drive4();
    for (int h = 0; h < 4; h++) begin
      b4.hosts_avn_read[h]        = act[h] & hrd[h];
      b4.hosts_avn_write[h]       = act[h] & hwr[h];
      b4.hosts_avn_address[h]     = haddr[h];
      b4.hosts_avn_byte_enable[h] = hbe[h];
      b4.hosts_avn_writedata[h]   = hdat[h];
    end
    b4.device_avn_waitrequest = dw4;
  endtask

  // One NH=4 cycle: drive, check against the model mid-cycle, advance the model, retire done hosts.
  task automatic cyc4();
    logic [3:0]    req;
    logic [3:0]    wexp;
    logic [3:0]    done;
    logic [DW-1:0] rdat;
    drive4();
    rdat = $urandom;
    b4.device_avn_readdata = rdat;
    @(negedge clk);
    for (int h = 0; h < 4; h++) req[h] = act[h] & (hrd[h] | hwr[h]);
    chk("rd4", b4.device_avn_read,  m_busy ? (act[m_owner] & hrd[m_owner]) : 1'b0);
    chk("wr4", b4.device_avn_write, m_busy ? (act[m_owner] & hwr[m_owner]) : 1'b0);
    chk("addr4", b4.device_avn_address, haddr[m_owner]);
    chk("be4", b4.device_avn_byte_enable, hbe[m_owner]);
    chk("wdat4", b4.device_avn_writedata, hdat[m_owner]);
    wexp = 4'hf;
    if (m_busy) wexp[m_owner] = dw4;
    chk("wait4", b4.hosts_avn_waitrequest, wexp);
    chk("rdat4", b4.hosts_avn_readdata, {4{rdat}});
    done = req & ~b4.hosts_avn_waitrequest;
    if (!b4.hosts_avn_waitrequest[1] || !b4.hosts_avn_waitrequest[3]) w13_low++;
    for (int h = 0; h < 4; h++) begin
      if (done[h]) begin
        obs.push_back(h);
        chk("starve", (others[h] <= 3), 1'b1);
        others[h] = 0;
        for (int o = 0; o < 4; o++) if (o != h && act[o]) others[o]++;
      end
    end
    if (!m_busy) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_next + i) % 4;
        if (req[c]) begin
          m_owner = c;
          m_busy  = 1'b1;
          break;
        end
      end
    end else if (!req[m_owner] || !dw4) begin
      m_busy = 1'b0;
      m_next = (m_owner + 1) % 4;
    end
    tick();
    for (int h = 0; h < 4; h++) begin
      if (done[h]) begin
        if (cont[h]) newtx(h);
        else act[h] = 1'b0;
      end
    end
  endtask

  initial begin
    int e35 [4];
    int e33 [4];
    e35 = '{3, 0, 1, 2};
    e33 = '{0, 2, 0, 2};
    b2.hosts_avn_read = '0;  b2.hosts_avn_write = '0;
    b2.hosts_avn_address = '0; b2.hosts_avn_byte_enable = '0; b2.hosts_avn_writedata = '0;
    b2.device_avn_readdata = '0; b2.device_avn_waitrequest = 1'b0;
    for (int h = 0; h < 4; h++) begin
      act[h] = 1'b0; hrd[h] = 1'b0; hwr[h] = 1'b0; haddr[h] = '0;
      hdat[h] = '0; hbe[h] = '0; cont[h] = 1'b0; others[h] = 0;
    end
    dw4 = 1'b0; w13_low = 0; m_busy = 1'b0; m_owner = 0; m_next = 0;
    drive4();
    b4.device_avn_readdata = '0;

    #3;
    chk("rst.rd2", b2.device_avn_read, 1'b0);
    chk("rst.wr2", b2.device_avn_write, 1'b0);
    chk("rst.wait2", b2.hosts_avn_waitrequest, 2'b11);
    chk("rst.wait4", b4.hosts_avn_waitrequest, 4'hf);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single read from host0, zero-wait device
    b2.hosts_avn_read[0] = 1'b1; b2.hosts_avn_address[0] = 32'h100;
    c2("rd_idle", 1'b0, 1'b0, 2'b11, 32'h100);
    tick();
    c2("rd_gnt", 1'b1, 1'b0, 2'b10, 32'h100);
    tick();
    b2.hosts_avn_read[0] = 1'b0;

    // host1 write stalled 3 cycles while host0 waits; host1 wins because ptr moved to 1
    b2.hosts_avn_write[1] = 1'b1; b2.hosts_avn_address[1] = 32'h300;
    b2.hosts_avn_writedata[1] = 32'hDEADBEEF; b2.hosts_avn_byte_enable[1] = 4'hf;
    b2.hosts_avn_read[0] = 1'b1; b2.hosts_avn_address[0] = 32'h200;
    b2.device_avn_waitrequest = 1'b1;
    c2("wr_idle", 1'b0, 1'b0, 2'b11, 32'h200);
    tick();
    for (int i = 0; i < 3; i++) begin
      c2("wr_stall", 1'b0, 1'b1, 2'b11, 32'h300);
      chk("wr_stall.wdat", b2.device_avn_writedata, 32'hDEADBEEF);
      chk("wr_stall.be", b2.device_avn_byte_enable, 4'hf);
      tick();
    end
    b2.device_avn_waitrequest = 1'b0;
    c2("wr_done", 1'b0, 1'b1, 2'b01, 32'h300);
    tick();
    b2.hosts_avn_write[1] = 1'b0;
    c2("h0_idle", 1'b0, 1'b0, 2'b11, 32'h300);
    tick();
    b2.device_avn_readdata = 32'h12345678;
    c2("h0_gnt", 1'b1, 1'b0, 2'b10, 32'h200);
    chk("rdat2", b2.hosts_avn_readdata, {2{32'h12345678}});
    tick();
    b2.hosts_avn_read[0] = 1'b0;

    // asynchronous reset while host1 owns a stalled device
    b2.hosts_avn_read = 2'b11;
    b2.hosts_avn_address[1] = 32'h400; b2.hosts_avn_address[0] = 32'h500;
    b2.device_avn_waitrequest = 1'b1;
    c2("rst_idle", 1'b0, 1'b0, 2'b11, 32'h500);
    tick();
    c2("rst_gnt", 1'b1, 1'b0, 2'b11, 32'h400);
    #2 rst = 1'b0;
    #1;
    chk("arst.rd", b2.device_avn_read, 1'b0);
    chk("arst.wr", b2.device_avn_write, 1'b0);
    chk("arst.wait", b2.hosts_avn_waitrequest, 2'b11);
    tick();
    tick();
    rst = 1'b1;
    c2("rel", 1'b0, 1'b0, 2'b11, 32'h500);
    tick();
    c2("rel_gnt0", 1'b1, 1'b0, 2'b11, 32'h500);
    tick();

    // owner abandons mid-stall: no access, back to idle, host1 next
    b2.hosts_avn_read[0] = 1'b0;
    c2("drop", 1'b0, 1'b0, 2'b11, 32'h500);
    tick();
    b2.device_avn_waitrequest = 1'b0;
    c2("drop_idle", 1'b0, 1'b0, 2'b11, 32'h500);
    tick();
    c2("drop_next", 1'b1, 1'b0, 2'b01, 32'h400);
    tick();
    b2.hosts_avn_read = '0;

    // NH=4 instance from a fresh reset
    rst = 1'b0;
    #1;
    chk("rst4.rd", b4.device_avn_read, 1'b0);
    chk("rst4.wait", b4.hosts_avn_waitrequest, 4'hf);
    tick();
    tick();
    rst = 1'b1;

    newtx(2);
    repeat (2) cyc4();
    obs.delete();
    for (int h = 0; h < 4; h++) newtx(h);
    repeat (8) cyc4();
    chk("ord35.n", obs.size(), 4);
    for (int i = 0; i < 4; i++) chk("ord35", (i < obs.size()) ? obs[i] : -1, e35[i]);

    obs.delete();
    w13_low = 0;
    cont[0] = 1'b1; cont[2] = 1'b1;
    newtx(0); newtx(2);
    repeat (8) cyc4();
    chk("ord33.n", obs.size(), 4);
    for (int i = 0; i < 4; i++) chk("ord33", (i < obs.size()) ? obs[i] : -1, e33[i]);
    chk("w13", w13_low, 0);
    cont[0] = 1'b0; cont[2] = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      for (int h = 0; h < 4; h++) begin
        if (!act[h] && $urandom_range(0, 99) < 30) newtx(h);
        else if (act[h] && $urandom_range(0, 99) < 3) begin
          act[h] = 1'b0;
          others[h] = 0;
        end
      end
      dw4 = ($urandom_range(0, 99) < 40);
      cyc4();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avalon_s_rr_arbiter.md
AVALON_S_RR_ARBITER -- requirements
Module: avalon_s_rr_arbiter

Interface
REQ-001 SHALL have parameter NH, default 2, number of hosts sharing one device (NH >= 2).
REQ-002 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have parameter AW, default 32, address width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port hosts_avn_read  input  [NH-1:0]  per-host read request.
REQ-007 SHALL have port hosts_avn_write  input  [NH-1:0]  per-host write request.
REQ-008 SHALL have port hosts_avn_address  input  [NH-1:0][AW-1:0]  per-host address.
REQ-009 SHALL have port hosts_avn_byte_enable  input  [NH-1:0][DW/8-1:0]  per-host byte enables.
REQ-010 SHALL have port hosts_avn_writedata  input  [NH-1:0][DW-1:0]  per-host write data.
REQ-011 SHALL have port hosts_avn_readdata  output  [NH-1:0][DW-1:0]  per-host read data.
REQ-012 SHALL have port hosts_avn_waitrequest  output  [NH-1:0]  per-host stall.
REQ-013 SHALL have ports device_avn_read/write (1), device_avn_address (AW), device_avn_byte_enable (DW/8), device_avn_writedata (DW), all output, driving the single device.
REQ-014 SHALL have ports device_avn_readdata  input  DW and device_avn_waitrequest  input  1.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one host owns the device).
REQ-016 SHALL hold a registered grant index gnt (clog2(NH) bits) and a round-robin pointer ptr (clog2(NH) bits).
REQ-017 SHALL treat host h as requesting when hosts_avn_read[h] | hosts_avn_write[h].
REQ-018 SHALL, in IDLE with any request, select the first requesting host searching ptr, ptr+1, ... modulo NH, load it into gnt, and move to GRANT next cycle.
REQ-019 SHALL remain in IDLE with gnt unchanged when no host requests.
REQ-020 SHALL, in GRANT, drive device address, byte_enable, writedata, read and write from host gnt.
REQ-021 SHALL, in IDLE, drive device_avn_read = 0 and device_avn_write = 0; other device outputs follow host gnt.
REQ-022 SHALL drive hosts_avn_waitrequest[gnt] = device_avn_waitrequest in GRANT; all other hosts, and all hosts in IDLE, see waitrequest = 1.
REQ-023 SHALL broadcast device_avn_readdata to every hosts_avn_readdata entry (only the granted host's is meaningful).
REQ-024 SHALL define completion as GRANT & (read|write of host gnt) & !device_avn_waitrequest.
REQ-025 SHALL, on completion, return to IDLE and set ptr = (gnt+1) mod NH in the same edge.
REQ-026 SHALL, in GRANT, if host gnt deasserts both read and write without completion, return to IDLE with ptr = (gnt+1) mod NH and no device access issued that cycle.
REQ-027 SHALL never assert device_avn_read and device_avn_write together unless host gnt does so.
REQ-028 SHALL give grant latency of 1 cycle (request seen in IDLE -> device access next cycle) and a minimum of 2 cycles per transfer.
REQ-029 SHALL guarantee every continuously requesting host completes within NH transfers of other hosts (no starvation).

Reset
REQ-030 SHALL, on rst low, asynchronously force state = IDLE, gnt = 0, ptr = 0, device_avn_read = 0, device_avn_write = 0, all hosts_avn_waitrequest = 1, including mid-transfer.
REQ-031 SHALL issue no device access in the cycle rst deasserts; arbitration begins on the first edge with rst high.

Verification
REQ-032 SHALL cover: NH=2, host0 read 0x100, device waitrequest 0 -> IDLE cycle 1, device_avn_read=1 address 0x100 cycle 2, host0 waitrequest 0 cycle 2, ptr=1 after.
REQ-033 SHALL cover: NH=4, hosts 0 and 2 request continuously, single-cycle device -> grants alternate 0,2,0,2; host1/3 waitrequest always 1.
REQ-034 SHALL cover: NH=2, host1 write 0xDEADBEEF, device waitrequest high 3 cycles -> device_avn_write held 4 cycles, host0 request stalled throughout, host0 granted next.
REQ-035 SHALL cover: NH=4, all hosts request from ptr=3 -> grant order 3,0,1,2.
REQ-036 SHALL cover: rst asserted low during GRANT with device waitrequest high -> device_avn_read/write 0 immediately (before next clk edge), gnt=0, ptr=0.
REQ-037 SHALL cover: granted host drops request mid-stall -> FSM returns to IDLE next edge, ptr advances, next requester granted one cycle later.
